black_box_div_uint8: RTL and testbench
======================================

BLACK_BOX_DIV_UINT8 -- requirements
Module: black_box_div_uint8

Interface
REQ-001 Parameter WIDTH, default 8: operand and result width in bits; legal values 2..16.
REQ-002 Port clock, input, 1: sole clock; all state updates on rising edge.
REQ-003 Port reset, input, 1: reset is synchronous and active-high.
REQ-004 Port I0, input, WIDTH: dividend, unsigned.
REQ-005 Port I1, input, WIDTH: divisor, unsigned.
REQ-006 Port valid_in, input, 1: I0/I1 carry a new operand pair this cycle.
REQ-007 Port O, output, WIDTH, registered: quotient floor(I0/I1).
REQ-008 Port R, output, WIDTH, registered: remainder I0 mod I1.
REQ-009 Port div_by_zero, output, 1, registered: the result on O/R came from I1 == 0.
REQ-010 Port valid_out, output, 1, registered: O/R/div_by_zero hold a result this cycle.

Function
REQ-011 The block SHALL be a fully pipelined restoring divider: one input-capture stage, then WIDTH iteration stages, each resolving one quotient bit from MSB to LSB.
REQ-012 The block SHALL accept a new operand pair every cycle with no stall, no backpressure and no ready signal.
REQ-013 Fixed latency L = WIDTH+1 edges: a pair sampled at edge k with valid_in=1 SHALL appear on O/R/div_by_zero with valid_out=1 immediately after edge k+L (L=9 for WIDTH=8).
REQ-014 Results SHALL leave in the same order operands entered; per-stage valid bits SHALL travel with the data, so gaps in valid_in reappear as identical gaps in valid_out.
REQ-015 Iteration stage i SHALL hold a partial remainder of WIDTH+1 bits: shift left, bring in the next dividend bit, subtract the divisor; set quotient bit i on non-negative difference, otherwise restore.
REQ-016 Divisor and dividend SHALL be carried alongside the partial results in every stage; no stage may read I0/I1 directly.
REQ-017 I1 == 0 SHALL produce O = all ones (2^WIDTH-1), R = I0 and div_by_zero=1; this is exactly what the restoring recurrence yields, and no special datapath is needed.
REQ-018 For I1 != 0, the outputs SHALL satisfy O*I1 + R == I0 with R < I1, and div_by_zero SHALL be 0.
REQ-019 When valid_out=0, O/R/div_by_zero SHALL hold their previous values; the bench SHALL NOT check them.
REQ-020 Input data with valid_in=0 SHALL NOT be required to be captured; stage data registers MAY update freely, but valid bits SHALL be exact.

Reset
REQ-021 At an edge with reset=1, every stage valid bit, valid_out, div_by_zero, O and R SHALL be cleared to 0.
REQ-022 A pair presented at an edge with reset=1 SHALL be discarded.
REQ-023 All in-flight pairs SHALL be discarded when reset is asserted mid-operation; no result for them SHALL ever appear.
REQ-024 The first valid pair after reset deassertion SHALL emerge exactly L edges after its capture edge.
REQ-025 Reset SHALL take effect in one cycle, with no multi-cycle requirement.

Verification
REQ-026 Single pair: I0=200, I1=7, one valid cycle -> 9 edges later valid_out=1, O=28, R=4, div_by_zero=0 for exactly one cycle.
REQ-027 Divide by zero: I0=5, I1=0 -> O=255, R=5, div_by_zero=1; then I0=0, I1=0 -> O=255, R=0, div_by_zero=1.
REQ-028 Back-to-back: 255/1, 255/255, 0/3, 17/16 on consecutive cycles -> consecutive outputs (255,0), (1,0), (0,0), (1,1) with valid_out held high for 4 cycles.
REQ-029 Gapped stream: valid_in pattern 1,0,1,1,0 -> valid_out pattern 1,0,1,1,0 delayed by 9 cycles, with matching data.
REQ-030 Reset mid-flight: three pairs issued, reset high for 1 cycle 4 edges later -> no valid_out for those pairs; a pair 100/9 issued after reset -> O=11, R=1 at L edges.
REQ-031 Exhaustive: all 65536 (I0,I1) pairs streamed back-to-back, checked against a model implementing REQ-017/REQ-018 -> zero mismatches; repeat for WIDTH=4.

Source files
------------

// File: rtl/black_box_div_uint8.sv
// Fully pipelined unsigned restoring divider: one capture stage, WIDTH iteration
// stages (one quotient bit each, MSB first) and a registered result stage.
module black_box_div_uint8 #(
    parameter int WIDTH = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] I0,
    input  logic [WIDTH-1:0] I1,
    input  logic             valid_in,
    output logic [WIDTH-1:0] O,
    output logic [WIDTH-1:0] R,
    output logic             div_by_zero,
    output logic             valid_out
);

    localparam int NSTG = WIDTH + 1;

    // Stage 0 is the capture stage; stage i (1..WIDTH) has resolved i quotient bits.
    // The dividend is carried pre-shifted so each stage consumes its MSB.
    logic [WIDTH-1:0] a_q   [NSTG];
    logic [WIDTH-1:0] a_d   [NSTG];
    logic [WIDTH-1:0] b_q   [NSTG];
    logic [WIDTH-1:0] b_d   [NSTG];
    logic [WIDTH:0]   rem_q [NSTG];
    logic [WIDTH:0]   rem_d [NSTG];
    logic [WIDTH-1:0] quo_q [NSTG];
    logic [WIDTH-1:0] quo_d [NSTG];
    logic             vld_q [NSTG];
    logic             vld_d [NSTG];

    logic [WIDTH-1:0] o_q;
    logic [WIDTH-1:0] o_d;
    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] r_d;
    logic             dbz_q;
    logic             dbz_d;
    logic             vout_q;
    logic             vout_d;

    // Capture stage plus one restoring iteration per pipeline stage.
    always_comb begin
        logic [WIDTH+1:0] shifted_s;
        logic [WIDTH+1:0] diff_s;
        shifted_s = '0;
        diff_s    = '0;
        a_d       = a_q;
        b_d       = b_q;
        rem_d     = rem_q;
        quo_d     = quo_q;
        vld_d     = vld_q;

        a_d[0]   = I0;
        b_d[0]   = I1;
        rem_d[0] = '0;
        quo_d[0] = '0;
        vld_d[0] = valid_in;

        for (int i = 1; i < NSTG; i++) begin
            shifted_s = {rem_q[i-1], a_q[i-1][WIDTH-1]};
            diff_s    = shifted_s - {2'b00, b_q[i-1]};
            a_d[i]    = {a_q[i-1][WIDTH-2:0], 1'b0};
            b_d[i]    = b_q[i-1];
            vld_d[i]  = vld_q[i-1];
            // Borrow out of the difference means the divisor did not fit: restore.
            if (diff_s[WIDTH+1]) begin
                rem_d[i] = shifted_s[WIDTH:0];
                quo_d[i] = {quo_q[i-1][WIDTH-2:0], 1'b0};
            end else begin
                rem_d[i] = diff_s[WIDTH:0];
                quo_d[i] = {quo_q[i-1][WIDTH-2:0], 1'b1};
            end
        end
    end

    // Result stage: load only when a valid result leaves the last iteration.
    always_comb begin
        o_d    = o_q;
        r_d    = r_q;
        dbz_d  = dbz_q;
        vout_d = vld_q[WIDTH];
        if (vld_q[WIDTH]) begin
            o_d   = quo_q[WIDTH];
            r_d   = rem_q[WIDTH][WIDTH-1:0];
            dbz_d = (b_q[WIDTH] == '0);
        end else begin
            o_d   = o_q;
            r_d   = r_q;
            dbz_d = dbz_q;
        end
    end

    // Valid bits and outputs: cleared by reset so in-flight pairs are dropped.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < NSTG; i++) begin
                vld_q[i] <= 1'b0;
            end
            o_q    <= '0;
            r_q    <= '0;
            dbz_q  <= 1'b0;
            vout_q <= 1'b0;
        end else begin
            for (int i = 0; i < NSTG; i++) begin
                vld_q[i] <= vld_d[i];
            end
            o_q    <= o_d;
            r_q    <= r_d;
            dbz_q  <= dbz_d;
            vout_q <= vout_d;
        end
    end

    // Stage datapath registers: qualified by the valid bits, so no reset needed.
    always_ff @(posedge clock) begin
        for (int i = 0; i < NSTG; i++) begin
            a_q[i]   <= a_d[i];
            b_q[i]   <= b_d[i];
            rem_q[i] <= rem_d[i];
            quo_q[i] <= quo_d[i];
        end
    end

    assign O           = o_q;
    assign R           = r_q;
    assign div_by_zero = dbz_q;
    assign valid_out   = vout_q;

endmodule

// File: tb/tb_black_box_div_uint8.sv
// Scoreboard bench for black_box_div_uint8 at WIDTH=8 and WIDTH=4: expected
// results are queued with their due cycle when driven and checked on output.
module tb_black_box_div_uint8;

    localparam int W8 = 8;
    localparam int L8 = W8 + 1;
    localparam int W4 = 4;
    localparam int L4 = W4 + 1;

    typedef struct {
        int a;
        int b;
        int due;
    } exp_t;

    logic          clock = 1'b0;
    logic          reset;
    logic [W8-1:0] i0_8, i1_8, o_8, r_8;
    logic          vin_8, dbz_8, vout_8;
    logic [W4-1:0] i0_4, i1_4, o_4, r_4;
    logic          vin_4, dbz_4, vout_4;

    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    logic mon_en   = 1'b0;
    exp_t q8[$];
    exp_t q4[$];

    black_box_div_uint8 #(.WIDTH(W8)) dut8 (
        .clock(clock), .reset(reset), .I0(i0_8), .I1(i1_8), .valid_in(vin_8),
        .O(o_8), .R(r_8), .div_by_zero(dbz_8), .valid_out(vout_8)
    );

    black_box_div_uint8 #(.WIDTH(W4)) dut4 (
        .clock(clock), .reset(reset), .I0(i0_4), .I1(i1_4), .valid_in(vin_4),
        .O(o_4), .R(r_4), .div_by_zero(dbz_4), .valid_out(vout_4)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    function automatic int exp_quo(input int a, input int b, input int w);
        return (b == 0) ? ((1 << w) - 1) : (a / b);
    endfunction

    function automatic int exp_rem(input int a, input int b);
        return (b == 0) ? a : (a % b);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, expv, cyc);
        end
    endtask

    // Output monitor for the 8-bit instance.
    always @(negedge clock) begin : mon8
        logic ev;
        if (mon_en) begin
            ev = (q8.size() > 0) && (q8[0].due == cyc);
            chk("valid_out_w8", {31'd0, vout_8}, {31'd0, ev});
            if (ev) begin
                chk("O_w8", {24'd0, o_8}, exp_quo(q8[0].a, q8[0].b, W8));
                chk("R_w8", {24'd0, r_8}, exp_rem(q8[0].a, q8[0].b));
                chk("dbz_w8", {31'd0, dbz_8}, (q8[0].b == 0) ? 32'd1 : 32'd0);
                void'(q8.pop_front());
            end
        end
    end

    // Output monitor for the 4-bit instance.
    always @(negedge clock) begin : mon4
        logic ev;
        if (mon_en) begin
            ev = (q4.size() > 0) && (q4[0].due == cyc);
            chk("valid_out_w4", {31'd0, vout_4}, {31'd0, ev});
            if (ev) begin
                chk("O_w4", {28'd0, o_4}, exp_quo(q4[0].a, q4[0].b, W4));
                chk("R_w4", {28'd0, r_4}, exp_rem(q4[0].a, q4[0].b));
                chk("dbz_w4", {31'd0, dbz_4}, (q4[0].b == 0) ? 32'd1 : 32'd0);
                void'(q4.pop_front());
            end
        end
    end

    task automatic put8(input logic v, input int a, input int b);
        vin_8 = v;
        i0_8  = a[W8-1:0];
        i1_8  = b[W8-1:0];
        if (v && !reset) q8.push_back('{a: a, b: b, due: cyc + 1 + L8});
    endtask

    task automatic put4(input logic v, input int a, input int b);
        vin_4 = v;
        i0_4  = a[W4-1:0];
        i1_4  = b[W4-1:0];
        if (v && !reset) q4.push_back('{a: a, b: b, due: cyc + 1 + L4});
    endtask

    task automatic step();
        @(posedge clock);
        #1;
        vin_8 = 1'b0;
        vin_4 = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        q8.delete();
        q4.delete();
        step();
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        put8(1'b0, 0, 0);
        put4(1'b0, 0, 0);
        repeat (2) @(posedge clock);
        #1;
        chk("rst_valid_out", {31'd0, vout_8}, 32'd0);
        chk("rst_O", {24'd0, o_8}, 32'd0);
        chk("rst_R", {24'd0, r_8}, 32'd0);
        chk("rst_dbz", {31'd0, dbz_8}, 32'd0);
        chk("rst_valid_out_w4", {31'd0, vout_4}, 32'd0);
        mon_en = 1'b1;

        // Pair presented while reset is high must vanish.
        put8(1'b1, 50, 5);
        step();
        reset = 1'b0;

        // Single pair: 200/7 -> 28 r 4.
        put8(1'b1, 200, 7);
        step();
        idle(L8 + 2);

        // Divide by zero.
        put8(1'b1, 5, 0);
        step();
        put8(1'b1, 0, 0);
        step();

        // Back-to-back stream.
        put8(1'b1, 255, 1);   step();
        put8(1'b1, 255, 255); step();
        put8(1'b1, 0, 3);     step();
        put8(1'b1, 17, 16);   step();

        // Gapped stream 1,0,1,1,0.
        put8(1'b1, 9, 2);     step();
        put8(1'b0, 77, 3);    step();
        put8(1'b1, 130, 11);  step();
        put8(1'b1, 64, 8);    step();
        put8(1'b0, 1, 1);     step();
        idle(L8 + 2);

        // Reset mid-flight: three pairs, reset edge 4 edges after the first capture.
        put8(1'b1, 40, 3); put4(1'b1, 7, 2); step();
        put8(1'b1, 41, 4); step();
        put8(1'b1, 42, 5); step();
        step();
        pulse_reset();
        put8(1'b1, 100, 9);
        step();
        idle(L8 + 2);

        // Directed 4-bit corners.
        put4(1'b1, 7, 0);  step();
        put4(1'b1, 15, 1); step();
        put4(1'b1, 13, 4); step();
        idle(L4 + 2);

        // Exhaustive streams for both widths, back-to-back.
        for (int a = 0; a < 256; a++) begin
            for (int b = 0; b < 256; b++) begin
                int idx;
                idx = a * 256 + b;
                put8(1'b1, a, b);
                if (idx < 256) put4(1'b1, idx >> 4, idx & 15);
                step();
            end
        end
        idle(L8 + 3);

        chk("drain_w8", q8.size(), 32'd0);
        chk("drain_w4", q4.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
